// File: rtl/bus_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef struct packed {
        logic                  mode;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] wstrb;
    } bus_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH,
        REQ_MEM
    } requester_t;

    // Flattened request payload width: mode + addr + wdata + wstrb.
    function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw + dw / 8;
    endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One-entry request capture register with pending and sticky overflow flags.
module arb_req_slot #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_en,
    input  logic [W-1:0] req_data,
    input  logic         clear,
    input  logic         in_flight,
    output logic         pending,
    output logic [W-1:0] data,
    output logic         overflow
);

    // A request while one is pending or in flight is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (clear) begin
                pending <= 1'b0;
            end
            if (req_en) begin
                if (pending || in_flight) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    data    <= req_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and mem ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is mem-over-fetch.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_req_en,
    input  logic                f_mode,
    input  logic [ADDR_W-1:0]   f_addr,
    input  logic [DATA_W-1:0]   f_wdata,
    input  logic [DATA_W/8-1:0] f_wstrb,
    output logic                f_resp_en,
    output logic [DATA_W-1:0]   f_resp_data,
    input  logic                m_req_en,
    input  logic                m_mode,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_resp_en,
    output logic [DATA_W-1:0]   m_resp_data,
    output logic                bus_req_en,
    output logic                bus_mode,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_resp_en,
    input  logic [DATA_W-1:0]   bus_resp_data,
    output logic                busy,
    output logic                protocol_err
);

    localparam int unsigned REQ_W = req_width(ADDR_W, DATA_W);

    arb_state_t       state, state_nxt;
    requester_t       owner, owner_nxt, win_c;
    logic             f_pend, m_pend, f_ovf, m_ovf;
    logic             f_clr_c, m_clr_c;
    logic [REQ_W-1:0] f_slot, m_slot, win_data_c;
    logic [REQ_W-1:0] bus_fields, bus_fields_nxt;
    logic             bus_req_en_nxt, busy_nxt;
    logic             f_resp_en_nxt, m_resp_en_nxt;
    logic [DATA_W-1:0] f_resp_data_nxt, m_resp_data_nxt;

`ifdef ARB_ROUND_ROBIN_EN
    requester_t last_owner;
`endif

    arb_req_slot #(.W(REQ_W)) u_f_slot (
        .clk       (clk),
        .rst       (rst),
        .req_en    (f_req_en),
        .req_data  ({f_mode, f_addr, f_wdata, f_wstrb}),
        .clear     (f_clr_c),
        .in_flight (state == WAIT && owner == REQ_FETCH),
        .pending   (f_pend),
        .data      (f_slot),
        .overflow  (f_ovf)
    );

    arb_req_slot #(.W(REQ_W)) u_m_slot (
        .clk       (clk),
        .rst       (rst),
        .req_en    (m_req_en),
        .req_data  ({m_mode, m_addr, m_wdata, m_wstrb}),
        .clear     (m_clr_c),
        .in_flight (state == WAIT && owner == REQ_MEM),
        .pending   (m_pend),
        .data      (m_slot),
        .overflow  (m_ovf)
    );

    assign {bus_mode, bus_addr, bus_wdata, bus_wstrb} = bus_fields;
    assign protocol_err = f_ovf | m_ovf;

    // Winner selection over the registered pending flags.
    always_comb begin
        win_c = REQ_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
        if (f_pend && m_pend) begin
            win_c = (last_owner == REQ_MEM) ? REQ_FETCH : REQ_MEM;
        end else if (m_pend) begin
            win_c = REQ_MEM;
        end
`else
        if (m_pend) begin
            win_c = REQ_MEM;
        end
`endif
        win_data_c = (win_c == REQ_MEM) ? m_slot : f_slot;
    end

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= REQ_FETCH;
            bus_req_en  <= 1'b0;
            bus_fields  <= '0;
            busy        <= 1'b0;
            f_resp_en   <= 1'b0;
            m_resp_en   <= 1'b0;
            f_resp_data <= '0;
            m_resp_data <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            bus_req_en  <= bus_req_en_nxt;
            bus_fields  <= bus_fields_nxt;
            busy        <= busy_nxt;
            f_resp_en   <= f_resp_en_nxt;
            m_resp_en   <= m_resp_en_nxt;
            f_resp_data <= f_resp_data_nxt;
            m_resp_data <= m_resp_data_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= REQ_MEM;
        end else if (state == IDLE && (f_pend || m_pend)) begin
            last_owner <= win_c;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (f_pend || m_pend) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus_resp_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and slot-control logic; bus fields and response data hold by default.
    always_comb begin
        bus_req_en_nxt  = 1'b0;
        bus_fields_nxt  = bus_fields;
        owner_nxt       = owner;
        busy_nxt        = (state_nxt != IDLE);
        f_resp_en_nxt   = 1'b0;
        m_resp_en_nxt   = 1'b0;
        f_resp_data_nxt = f_resp_data;
        m_resp_data_nxt = m_resp_data;
        f_clr_c         = 1'b0;
        m_clr_c         = 1'b0;
        case (state)
            IDLE: begin
                if (f_pend || m_pend) begin
                    bus_req_en_nxt = 1'b1;
                    bus_fields_nxt = win_data_c;
                    owner_nxt      = win_c;
                end
            end
            ISSUE: begin
                if (owner == REQ_MEM) begin
                    m_clr_c = 1'b1;
                end else begin
                    f_clr_c = 1'b1;
                end
            end
            WAIT: begin
                if (bus_resp_en) begin
                    if (owner == REQ_MEM) begin
                        m_resp_en_nxt   = 1'b1;
                        m_resp_data_nxt = bus_resp_data;
                    end else begin
                        f_resp_en_nxt   = 1'b1;
                        f_resp_data_nxt = bus_resp_data;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_mem_bus_arbiter;
    import bus_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req_en, f_mode, m_req_en, m_mode;
    logic [AW-1:0] f_addr, m_addr;
    logic [DW-1:0] f_wdata, m_wdata;
    logic [SW-1:0] f_wstrb, m_wstrb;
    logic          f_resp_en, m_resp_en;
    logic [DW-1:0] f_resp_data, m_resp_data;
    logic          bus_req_en, bus_mode;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [SW-1:0] bus_wstrb;
    logic          bus_resp_en;
    logic [DW-1:0] bus_resp_data;
    logic          busy, protocol_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .f_req_en(f_req_en), .f_mode(f_mode), .f_addr(f_addr), .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_resp_en(f_resp_en), .f_resp_data(f_resp_data),
        .m_req_en(m_req_en), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_en(m_resp_en), .m_resp_data(m_resp_data),
        .bus_req_en(bus_req_en), .bus_mode(bus_mode), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_resp_en(bus_resp_en), .bus_resp_data(bus_resp_data),
        .busy(busy), .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        f_req_en = 1'b0; f_mode = 1'b0; f_addr = '0; f_wdata = '0; f_wstrb = '0;
        m_req_en = 1'b0; m_mode = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        bus_resp_en = 1'b0; bus_resp_data = '0;
    endtask

    task automatic drive_req(input int who, input bus_req_t r);
        if (who == 0) begin
            f_req_en = 1'b1; f_mode = r.mode; f_addr = r.addr; f_wdata = r.wdata; f_wstrb = r.wstrb;
        end else begin
            m_req_en = 1'b1; m_mode = r.mode; m_addr = r.addr; m_wdata = r.wdata; m_wstrb = r.wstrb;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_f_resp_en"},   64'(f_resp_en), 64'(0));
        chk({tag, "_m_resp_en"},   64'(m_resp_en), 64'(0));
        chk({tag, "_f_resp_data"}, 64'(f_resp_data), 64'(0));
        chk({tag, "_m_resp_data"}, 64'(m_resp_data), 64'(0));
        chk({tag, "_bus_req_en"},  64'(bus_req_en), 64'(0));
        chk({tag, "_bus_fields"},  64'({bus_mode, bus_addr, bus_wstrb}), 64'(0));
        chk({tag, "_bus_wdata"},   64'(bus_wdata), 64'(0));
        chk({tag, "_busy"},        64'(busy), 64'(0));
        chk({tag, "_protocol_err"}, 64'(protocol_err), 64'(0));
    endtask

    // Transaction-level reference: each requester holds at most one outstanding request,
    // an idle arbiter issues two cycles after a visible pulse, responses return one cycle later.
    task automatic rand_phase(input int ncyc, input bit allow_viol);
        bus_req_t      preq[2];
        bus_req_t      cur;
        bus_req_t      r;
        bit            pv[2];
        int            pcyc[2];
        logic [DW-1:0] exp_rd[2];
        bit            act, resp_sent;
        int            own, resp_due, resp_cyc, idle_from, lastown, perr_from;
        logic [DW-1:0] resp_dat;
        do_reset();
        pv[0] = 0; pv[1] = 0; pcyc[0] = 0; pcyc[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        act = 0; resp_sent = 0; own = 0; resp_due = 0; resp_cyc = 0;
        idle_from = 0; lastown = 1; perr_from = 1 << 30; resp_dat = '0;
        cur = '0;
        for (int n = 0; n < ncyc; n++) begin
            bit exp_re[2];
            bit vis[2];
            int win;
            exp_re[0] = 0; exp_re[1] = 0;
            if (resp_sent && resp_cyc == cyc - 1) begin
                exp_re[own] = 1;
                exp_rd[own] = resp_dat;
                act = 0;
                resp_sent = 0;
                idle_from = cyc;
            end
            win = -1;
            for (int i = 0; i < 2; i++) vis[i] = pv[i] && (pcyc[i] <= cyc - 2);
            if (!act && (cyc - 1 >= idle_from) && (vis[0] || vis[1])) begin
                if (vis[0] && vis[1]) win = RR ? ((lastown == 1) ? 0 : 1) : 1;
                else win = vis[1] ? 1 : 0;
            end
            chk("rnd_bus_req_en", 64'(bus_req_en), 64'(win >= 0));
            if (win >= 0) begin
                act = 1; own = win; cur = preq[win]; pv[win] = 0; lastown = win;
                resp_due = cyc + int'($urandom_range(1, 4));
            end
            chk("rnd_busy", 64'(busy), 64'(act));
            if (act) begin
                chk("rnd_bus_fields", 64'({bus_mode, bus_addr, bus_wstrb}), 64'({cur.mode, cur.addr, cur.wstrb}));
                chk("rnd_bus_wdata", 64'(bus_wdata), 64'(cur.wdata));
            end
            chk("rnd_f_resp_en", 64'(f_resp_en), 64'(exp_re[0]));
            chk("rnd_m_resp_en", 64'(m_resp_en), 64'(exp_re[1]));
            chk("rnd_f_resp_data", 64'(f_resp_data), 64'(exp_rd[0]));
            chk("rnd_m_resp_data", 64'(m_resp_data), 64'(exp_rd[1]));
            chk("rnd_protocol_err", 64'(protocol_err), 64'(cyc >= perr_from));
            clear_inputs();
            bus_resp_data = $urandom;
            if (act && cyc == resp_due) begin
                bus_resp_en = 1'b1;
                resp_sent = 1; resp_cyc = cyc; resp_dat = bus_resp_data;
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r.mode = 1'($urandom); r.addr = $urandom; r.wdata = $urandom; r.wstrb = 4'($urandom);
                    if (pv[i] || (act && own == i)) begin
                        if (allow_viol && $urandom_range(0, 7) == 0) begin
                            drive_req(i, r);
                            if (perr_from > cyc + 1) perr_from = cyc + 1;
                        end
                    end else begin
                        drive_req(i, r);
                        pv[i] = 1; pcyc[i] = cyc; preq[i] = r;
                    end
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bus_req_t r;
        rst = 1'b1;
        clear_inputs();
        do_reset();
        check_reset_values("reset");

        // Lone fetch read.
        r = '{mode: MODE_READ, addr: 32'h100, wdata: 32'h0, wstrb: 4'h0};
        drive_req(0, r);
        tick(); clear_inputs();
        chk("lone_c1_req", 64'(bus_req_en), 64'(0));
        tick();
        chk("lone_c2_req", 64'(bus_req_en), 64'(1));
        chk("lone_c2_addr", 64'(bus_addr), 64'(32'h100));
        chk("lone_c2_mode", 64'(bus_mode), 64'(0));
        chk("lone_c2_busy", 64'(busy), 64'(1));
        tick();
        chk("lone_c3_req", 64'(bus_req_en), 64'(0));
        chk("lone_c3_addr", 64'(bus_addr), 64'(32'h100));
        tick(); tick();
        bus_resp_en = 1'b1; bus_resp_data = 32'hDEADBEEF;
        tick(); clear_inputs();
        chk("lone_c6_f_resp_en", 64'(f_resp_en), 64'(1));
        chk("lone_c6_f_resp_data", 64'(f_resp_data), 64'(32'hDEADBEEF));
        chk("lone_c6_m_resp_en", 64'(m_resp_en), 64'(0));
        chk("lone_c6_busy", 64'(busy), 64'(0));
        tick();
        chk("lone_c7_f_resp_en", 64'(f_resp_en), 64'(0));

        // Simultaneous requests: mem first, fetch two cycles after the mem response.
        r = '{mode: MODE_WRITE, addr: 32'h200, wdata: 32'h12345678, wstrb: 4'hF};
        drive_req(1, r);
        r = '{mode: MODE_READ, addr: 32'h300, wdata: 32'h0, wstrb: 4'h0};
        drive_req(0, r);
        tick(); clear_inputs();
        tick();
        chk("sim_m_req", 64'(bus_req_en), 64'(1));
        chk("sim_m_fields", 64'({bus_mode, bus_addr, bus_wstrb}), 64'({1'b1, 32'h200, 4'hF}));
        chk("sim_m_wdata", 64'(bus_wdata), 64'(32'h12345678));
        tick();
        bus_resp_en = 1'b1; bus_resp_data = 32'hAAAA0001;
        tick(); clear_inputs();
        chk("sim_m_resp_en", 64'(m_resp_en), 64'(1));
        chk("sim_m_resp_data", 64'(m_resp_data), 64'(32'hAAAA0001));
        chk("sim_f_resp_en0", 64'(f_resp_en), 64'(0));
        chk("sim_f_hold", 64'(f_resp_data), 64'(32'hDEADBEEF));
        chk("sim_gap_req", 64'(bus_req_en), 64'(0));
        tick();
        chk("sim_f_req", 64'(bus_req_en), 64'(1));
        chk("sim_f_fields", 64'({bus_mode, bus_addr}), 64'({1'b0, 32'h300}));
        tick();
        bus_resp_en = 1'b1; bus_resp_data = 32'h55;
        tick(); clear_inputs();
        chk("sim_f_resp_en", 64'(f_resp_en), 64'(1));
        chk("sim_f_resp_data", 64'(f_resp_data), 64'(32'h55));
        chk("sim_m_resp_en0", 64'(m_resp_en), 64'(0));
        chk("sim_m_hold", 64'(m_resp_data), 64'(32'hAAAA0001));

        // Stray response in IDLE.
        tick();
        bus_resp_en = 1'b1; bus_resp_data = 32'hBAD;
        tick(); clear_inputs();
        chk("stray_f_resp_en", 64'(f_resp_en), 64'(0));
        chk("stray_m_resp_en", 64'(m_resp_en), 64'(0));
        chk("stray_data_hold", 64'({f_resp_data, m_resp_data}), {32'h55, 32'hAAAA0001});
        chk("stray_busy", 64'(busy), 64'(0));
        tick();
        chk("stray_no_req", 64'(bus_req_en), 64'(0));
        chk("stray_busy2", 64'(busy), 64'(0));

        // Overflow: second fetch pulse while the first is in WAIT.
        do_reset();
        r = '{mode: MODE_READ, addr: 32'h400, wdata: 32'h0, wstrb: 4'h0};
        drive_req(0, r);
        tick(); clear_inputs();
        tick();
        chk("ovf_req", 64'(bus_req_en), 64'(1));
        tick();
        r = '{mode: MODE_WRITE, addr: 32'h999, wdata: 32'h1, wstrb: 4'h1};
        drive_req(0, r);
        chk("ovf_err_before", 64'(protocol_err), 64'(0));
        tick(); clear_inputs();
        chk("ovf_err_set", 64'(protocol_err), 64'(1));
        bus_resp_en = 1'b1; bus_resp_data = 32'h1234;
        tick(); clear_inputs();
        chk("ovf_resp", 64'(f_resp_en), 64'(1));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_req_en) cnt++;
        end
        chk("ovf_no_second_issue", 64'(cnt), 64'(0));
        chk("ovf_err_sticky", 64'(protocol_err), 64'(1));
        do_reset();
        chk("ovf_err_cleared", 64'(protocol_err), 64'(0));

        // Reset during WAIT abandons the transaction.
        r = '{mode: MODE_WRITE, addr: 32'h40, wdata: 32'hCAFE, wstrb: 4'h3};
        drive_req(1, r);
        tick(); clear_inputs();
        tick();
        chk("rstw_req", 64'(bus_req_en), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rstw");
        bus_resp_en = 1'b1; bus_resp_data = 32'h77;
        tick(); clear_inputs();
        chk("rstw_no_m_resp", 64'(m_resp_en), 64'(0));
        chk("rstw_no_f_resp", 64'(f_resp_en), 64'(0));
        chk("rstw_m_data", 64'(m_resp_data), 64'(0));
        r = '{mode: MODE_READ, addr: 32'h44, wdata: 32'h0, wstrb: 4'h0};
        drive_req(1, r);
        tick(); clear_inputs();
        tick();
        chk("rstw_new_req", 64'(bus_req_en), 64'(1));
        chk("rstw_new_fields", 64'({bus_mode, bus_addr}), 64'({1'b0, 32'h44}));
        tick();
        bus_resp_en = 1'b1; bus_resp_data = 32'h99;
        tick(); clear_inputs();
        chk("rstw_new_resp_en", 64'(m_resp_en), 64'(1));
        chk("rstw_new_resp_data", 64'(m_resp_data), 64'(32'h99));

        // Pulse in the reset cycle is discarded.
        rst = 1'b1;
        r = '{mode: MODE_READ, addr: 32'h500, wdata: 32'h0, wstrb: 4'h0};
        drive_req(0, r);
        tick();
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstpulse_no_req", 64'({bus_req_en, busy}), 64'(0));
        end

        // Randomized traffic: legal only, then with protocol violations.
        rand_phase(400, 1'b0);
        rand_phase(400, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
